down_counter_4bit: RTL

DOWN_COUNTER_4BIT -- requirements
Module: down_counter_4bit

---
 rtl/down_counter_pkg.sv | 12 +
 rtl/down_counter_4bit.sv | 96 +++++++++
 2 files changed

// File: rtl/down_counter_pkg.sv
// Shared types and constants for the loadable down counter.
package down_counter_pkg;

   localparam int unsigned COUNT_WIDTH = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : down_counter_pkg

// File: rtl/down_counter_4bit.sv
// Loadable down counter with start/stop control and a one-cycle terminal-count pulse.
// Define DOWN_COUNTER_AUTO_RELOAD_EN to restart from the reload register after DONE.
module down_counter_4bit
   import down_counter_pkg::*;
#(
   parameter int unsigned WIDTH = COUNT_WIDTH
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic             stop,
   output logic [WIDTH-1:0] count,
   output logic             busy,
   output logic             done,
   output logic             zero
);

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
   localparam bit AUTO_RELOAD = 1'b1;
`else
   localparam bit AUTO_RELOAD = 1'b0;
`endif

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] count_next;
   logic [WIDTH-1:0] reload;
   logic [WIDTH-1:0] reload_next;

   // State and datapath registers; busy/done are registered decodes of the next state
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state  <= IDLE;
         count  <= '0;
         reload <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         state  <= state_next;
         count  <= count_next;
         reload <= reload_next;
         busy   <= (state_next == RUN);
         done   <= (state_next == DONE);
      end
   end

   // Next-state and datapath logic, priority load > stop > start
   always_comb begin
      state_next  = state;
      count_next  = count;
      reload_next = reload;
      if (load) begin
         count_next  = load_data;
         reload_next = load_data;
         state_next  = IDLE;
      end else begin
         unique case (state)
            IDLE: begin
               if (stop) begin
                  state_next = IDLE;
               end else if (start) begin
                  state_next = (count != '0) ? RUN : DONE;
               end
            end
            RUN: begin
               if (stop) begin
                  state_next = IDLE;
               end else if ((count == WIDTH'(1)) || (count == '0)) begin
                  // Terminal edge: saturate at zero rather than wrap
                  count_next = '0;
                  state_next = DONE;
               end else begin
                  count_next = count - WIDTH'(1);
               end
            end
            DONE: begin
               if (AUTO_RELOAD && (reload != '0)) begin
                  count_next = reload;
                  state_next = RUN;
               end else begin
                  count_next = '0;
                  state_next = IDLE;
               end
            end
            default: begin
               state_next = IDLE;
            end
         endcase
      end
   end

   assign zero = (count == '0);

endmodule : down_counter_4bit
